filter_line_sequencer: RTL and testbench

- Sequencer that drives a 3x3 line-buffered filter core with row-wide write enable, 10-bit column cursor, 16-bit data in, d_out and d_rdy.
- Accepts a raster pixel stream from the frame reader and writes one row at a time into the core's line buffers.
- After every row from the third onward, sweeps the cursor across the row, collects filtered pixels and emits them as a valid/ready stream to the frame writer.

---
 rtl/filter_seq_pkg.sv | 18 +
 rtl/filter_seq_out_stage.sv | 33 +++
 rtl/filter_line_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_filter_line_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/filter_seq_pkg.sv
// Shared types and constants for the 3x3 filter line sequencer.
// Optional read-timeout support is enabled with FILTER_SEQ_TIMEOUT_EN.
package filter_seq_pkg;

    localparam int unsigned CURSOR_W   = 10;
    localparam logic [15:0] BORDER_PIX = 16'h0000;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StGap,
        StSweep,
        StRdwait,
        StEmit,
        StRowend
    } seq_state_e;

endpackage

// File: rtl/filter_seq_out_stage.sv
// Single-entry output holding register: a loaded pixel stays on out_pix with
// out_valid high until the downstream accepts it.
module filter_seq_out_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_pix,
    input  logic        out_ready,
    output logic [15:0] out_pix,
    output logic        out_valid,
    output logic        handshake
);

    logic [15:0] pix_q;
    logic        valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_q   <= 16'h0000;
            valid_q <= 1'b0;
        end else if (load) begin
            pix_q   <= load_pix;
            valid_q <= 1'b1;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_pix   = pix_q;
    assign out_valid = valid_q;
    assign handshake = valid_q & out_ready;

endmodule

// File: rtl/filter_line_sequencer.sv
// Row writer / sweep sequencer for a 3x3 line-buffered filter core.
// Define FILTER_SEQ_TIMEOUT_EN to bound the wait for flt_d_rdy and flag err_timeout.
module filter_line_sequencer
    import filter_seq_pkg::*;
#(
    parameter int unsigned LINE_WIDTH     = 720,
    parameter int unsigned FRAME_ROWS     = 480,
    parameter int unsigned SETTLE_CYCLES  = 3,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [15:0] pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        flt_wren,
    output logic [9:0]  flt_cursor,
    output logic [15:0] flt_d_in,
    input  logic [15:0] flt_d_out,
    input  logic        flt_d_rdy,
    output logic [15:0] out_pix,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        err_timeout
);

    localparam logic [CURSOR_W-1:0] LAST_COL  = CURSOR_W'(LINE_WIDTH - 1);
    localparam logic [CURSOR_W-1:0] LAST_ROW  = CURSOR_W'(FRAME_ROWS - 1);
    localparam logic [CURSOR_W-1:0] THIRD_ROW = CURSOR_W'(2);
    localparam logic [15:0] SETTLE_LAST =
        (SETTLE_CYCLES > 0) ? 16'(SETTLE_CYCLES - 1) : 16'd0;

    seq_state_e          state_q, state_d;
    logic [CURSOR_W-1:0] col_q, col_d;
    logic [CURSOR_W-1:0] row_q, row_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [CURSOR_W-1:0] cursor_q, cursor_d;
    logic [15:0]         d_in_q, d_in_d;
    logic                pix_ready_q;
    logic                wren_q;
    logic                busy_q;
    logic                done_q, done_d;
    logic                load;
    logic [15:0]         load_pix;
    logic                out_hs;
    logic                accept;

`ifdef FILTER_SEQ_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST =
        (TIMEOUT_CYCLES > 0) ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;
    logic err_q;
    logic err_set;
    logic err_clr;
`else
    logic unused_timeout;
    assign unused_timeout = ^16'(TIMEOUT_CYCLES);
`endif

    assign accept = pix_valid & pix_ready_q;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        cursor_d = cursor_q;
        d_in_d   = d_in_q;
        done_d   = 1'b0;
        load     = 1'b0;
        load_pix = BORDER_PIX;
`ifdef FILTER_SEQ_TIMEOUT_EN
        err_set  = 1'b0;
        err_clr  = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d = StWrite;
                    row_d   = '0;
                    col_d   = '0;
`ifdef FILTER_SEQ_TIMEOUT_EN
                    err_clr = 1'b1;
`endif
                end
            end
            StWrite: begin
                if (accept) begin
                    d_in_d   = pix_in;
                    cursor_d = col_q;
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        state_d = StGap;
                    end else begin
                        col_d = col_q + 10'd1;
                    end
                end
            end
            StGap: begin
                col_d = '0;
                if (row_q < THIRD_ROW) begin
                    row_d   = row_q + 10'd1;
                    state_d = StWrite;
                end else begin
                    state_d = StSweep;
                end
            end
            StSweep: begin
                if (col_q == '0 || col_q == LAST_COL) begin
                    load     = 1'b1;
                    load_pix = BORDER_PIX;
                    state_d  = StEmit;
                end else if (cnt_q >= SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = StRdwait;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRdwait: begin
                if (flt_d_rdy) begin
                    load     = 1'b1;
                    load_pix = flt_d_out;
                    state_d  = StEmit;
                end
`ifdef FILTER_SEQ_TIMEOUT_EN
                else if (cnt_q >= TIMEOUT_LAST) begin
                    load     = 1'b1;
                    load_pix = BORDER_PIX;
                    err_set  = 1'b1;
                    state_d  = StEmit;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            StEmit: begin
                if (out_hs) begin
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        state_d = StRowend;
                    end else begin
                        col_d   = col_q + 10'd1;
                        state_d = StSweep;
                    end
                end
            end
            StRowend: begin
                if (row_q == LAST_ROW) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    row_d   = row_q + 10'd1;
                    col_d   = '0;
                    state_d = StWrite;
                end
            end
            default: state_d = StIdle;
        endcase

        // The cursor must already be on the column for the whole settle window.
        if (state_d == StSweep && state_q != StSweep) begin
            cnt_d = '0;
            if (col_d != '0 && col_d != LAST_COL) begin
                cursor_d = col_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            cnt_q       <= '0;
            cursor_q    <= '0;
            d_in_q      <= '0;
            pix_ready_q <= 1'b0;
            wren_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            cursor_q    <= cursor_d;
            d_in_q      <= d_in_d;
            pix_ready_q <= (state_d == StWrite);
            // Lags the state by one cycle so the last pixel of a row is still written.
            wren_q      <= (state_q == StWrite);
            busy_q      <= (state_d != StIdle);
            done_q      <= done_d;
        end
    end

`ifdef FILTER_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    filter_seq_out_stage u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_pix  (load_pix),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_valid (out_valid),
        .handshake (out_hs)
    );

    assign pix_ready  = pix_ready_q;
    assign flt_wren   = wren_q;
    assign flt_cursor = cursor_q;
    assign flt_d_in   = d_in_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_filter_line_sequencer.sv
// Self-checking bench for filter_line_sequencer with a behavioural line-buffer core.
module tb_filter_line_sequencer;

    localparam int LW   = 8;
    localparam int FR   = 4;
    localparam int NIN  = LW * FR;
    localparam int NOUT = (FR - 2) * LW;

    logic        clk;
    logic        reset;
    logic        frame_start;
    logic [15:0] pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic        flt_wren;
    logic [9:0]  flt_cursor;
    logic [15:0] flt_d_in;
    logic [15:0] flt_d_out;
    logic        flt_d_rdy;
    logic [15:0] out_pix;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        frame_done;
    logic        err_timeout;

    filter_line_sequencer #(
        .LINE_WIDTH     (LW),
        .FRAME_ROWS     (FR),
        .SETTLE_CYCLES  (3),
        .TIMEOUT_CYCLES (15)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_in      (pix_in),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .flt_wren    (flt_wren),
        .flt_cursor  (flt_cursor),
        .flt_d_in    (flt_d_in),
        .flt_d_out   (flt_d_out),
        .flt_d_rdy   (flt_d_rdy),
        .out_pix     (out_pix),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: newest written row per column, result = stored pixel + 1.
    logic [15:0] mem [1024];
    always_ff @(posedge clk) begin
        if (flt_wren) mem[flt_cursor] <= flt_d_in;
    end
    assign flt_d_out = mem[flt_cursor] + 16'd1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({pix_ready, flt_wren, flt_cursor, flt_d_in, out_pix, out_valid,
                    busy, frame_done, err_timeout});
    endfunction

    typedef struct {
        int vld_pct;
        int ordy_pct;
        int crdy_pct;
        int stall_at;
        int abort_at;
        int exp_out;
        int exp_rises;
        int exp_done;
    } vec_t;

    vec_t tbl[$];

    task automatic run_frame(input vec_t v);
        logic [15:0] img [NIN];
        logic [15:0] expq [NOUT];
        int idx = 0, hs = 0, last_hs = -10, rises = 0, dones = 0;
        int stall_left = 0, pend_col = 0;
        logic stalled = 0, pend_acc = 0, prev_wren = 0, finished = 0, aborted = 0;
        logic [15:0] pend_data = 0;
        logic [9:0] prev_cursor = flt_cursor;
        logic exp_err;

        for (int i = 0; i < NIN; i++) img[i] = 16'($urandom);
        for (int k = 0; k < NOUT; k++) begin
            int r = k / LW + 2;
            int c = k % LW;
            if (c == 0 || c == LW - 1 || v.crdy_pct == 0) expq[k] = 16'h0000;
            else expq[k] = img[r * LW + c] + 16'd1;
        end

        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            @(negedge clk);
            if (pend_acc) begin
                check("wr_cursor", 64'(flt_cursor), 64'(pend_col));
                check("wr_data", 64'(flt_d_in), 64'(pend_data));
            end else if (pix_ready) begin
                check("cursor_hold", 64'(flt_cursor), 64'(prev_cursor));
            end
            if (pix_ready && (idx % LW) != 0) check("wren_in_row", 64'(flt_wren), 64'd1);
            if (flt_wren && !prev_wren) rises++;
            prev_wren   = flt_wren;
            prev_cursor = flt_cursor;
            pend_acc    = 1'b0;
            check("wren_vs_valid", 64'(flt_wren & out_valid), 64'd0);
            check("frame_done", 64'(frame_done), 64'(hs == NOUT && cyc == last_hs + 2));
            if (frame_done) dones++;
            if (cyc == 2) check("err_cleared", 64'(err_timeout), 64'd0);
            if (hs == NOUT && cyc == last_hs + 3) begin
                check("idle_busy", 64'(busy), 64'd0);
                finished = 1'b1;
            end

            if (v.abort_at >= 0 && hs == v.abort_at && !out_valid && busy) begin
                frame_start = 1'b0;
                pix_valid   = 1'b0;
                reset       = 1'b1;
                #1;
                check("abort_outputs", all_outputs(), 64'd0);
                @(negedge clk);
                check("abort_held", all_outputs(), 64'd0);
                reset   = 1'b0;
                aborted = 1'b1;
                break;
            end

            frame_start = (cyc == 0) || (cyc == 25);
            if (cyc == 25) check("busy_on_ignored_start", 64'(busy), 64'd1);
            pix_valid = (idx < NIN) && (int'($urandom_range(99)) < v.vld_pct);
            pix_in    = (idx < NIN) ? img[idx] : 16'($urandom);
            if (pix_valid && pix_ready) begin
                pend_acc  = 1'b1;
                pend_col  = idx % LW;
                pend_data = img[idx];
                idx++;
            end
            flt_d_rdy = int'($urandom_range(99)) < v.crdy_pct;

            if (out_valid && hs == v.stall_at && !stalled) begin
                stalled    = 1'b1;
                stall_left = 5;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_pix", 64'(out_pix), 64'(expq[hs]));
                stall_left--;
            end else begin
                out_ready = int'($urandom_range(99)) < v.ordy_pct;
            end
            if (out_valid && out_ready) begin
                check("out_in_range", 64'(hs < NOUT), 64'd1);
                if (hs < NOUT) check("out_pix", 64'(out_pix), 64'(expq[hs]));
                hs++;
                last_hs = cyc;
            end
        end

        frame_start = 1'b0;
        pix_valid   = 1'b0;
        check("out_total", 64'(hs), 64'(v.exp_out));
        check("wren_rises", 64'(rises), 64'(v.exp_rises));
        check("done_pulses", 64'(dones), 64'(v.exp_done));
        if (aborted) check("abort_no_done", 64'(frame_done), 64'd0);
`ifdef FILTER_SEQ_TIMEOUT_EN
        exp_err = !aborted && (v.crdy_pct == 0);
`else
        exp_err = 1'b0;
`endif
        check("err_timeout", 64'(err_timeout), 64'(exp_err));
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        pix_in      = 16'h0000;
        pix_valid   = 1'b0;
        flt_d_rdy   = 1'b0;
        out_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", all_outputs(), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", all_outputs(), 64'd0);

        //              vld ordy crdy stall abort out   rises done
        tbl.push_back('{100, 100, 100,  -1,  -1, NOUT, FR, 1});
        tbl.push_back('{ 50, 100,  70,  -1,  -1, NOUT, FR, 1});
        tbl.push_back('{100, 100, 100,   5,  -1, NOUT, FR, 1});
        tbl.push_back('{ 60,  50,  60,  -1,   3,    3,  3, 0});
        tbl.push_back('{100, 100, 100,  -1,  -1, NOUT, FR, 1});
        tbl.push_back('{ 30,  40,  80,  10,  -1, NOUT, FR, 1});
`ifdef FILTER_SEQ_TIMEOUT_EN
        tbl.push_back('{100, 100,   0,   3,  -1, NOUT, FR, 1});
        tbl.push_back('{100, 100, 100,  -1,  -1, NOUT, FR, 1});
`endif

        for (int t = 0; t < tbl.size(); t++) run_frame(tbl[t]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
